// File: rtl/rv32i_pkg.sv
// Shared constants for the rv32i core: canonical NOP, IF/ID buffer state encoding and XLEN.
package rv32i_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0]  ST_EMPTY  = 2'b00;
  localparam logic [1:0]  ST_ONE    = 2'b10;
  localparam logic [1:0]  ST_FULL   = 2'b11;

endpackage

// File: rtl/pipe_slot.sv
// One buffer entry: valid bit plus payload, payload written only on load.
module pipe_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear_valid,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  // clear_valid wins so a flush never leaves a stale entry marked valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              vld <= 1'b0;
    else if (clear_valid) vld <= 1'b0;
    else if (load)        vld <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register: two-entry skid buffer with flush and a saturating bubble counter.
module if_id_skid_reg #(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] bubble_cnt
);
  import rv32i_pkg::*;

  localparam int               PW      = XLEN + 32;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic          main_vld_p0, skid_vld_p0;
  logic [PW-1:0] main_q_p0, skid_q_p0, main_d;
  logic          main_load, main_clr, main_from_skid;
  logic          skid_load, skid_clr;
  logic          in_fire, out_fire;
  logic [1:0]    state;

  assign state    = {main_vld_p0, skid_vld_p0};
  assign in_ready = ~skid_vld_p0;
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = main_vld_p0 & out_ready;

  // Next-state/control decode; the state register is the pair of slot valid bits.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = in_fire;
        ST_ONE: begin
          if (in_fire && out_fire)  main_load = 1'b1;
          else if (in_fire)         skid_load = 1'b1;
          else if (out_fire)        main_clr  = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q_p0 : {in_pc, in_instr};

  pipe_slot #(.W(PW)) u_main (
    .clk         (clk),
    .rst         (rst),
    .load        (main_load),
    .clear_valid (main_clr),
    .d           (main_d),
    .vld         (main_vld_p0),
    .q           (main_q_p0)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .load        (skid_load),
    .clear_valid (skid_clr),
    .d           ({in_pc, in_instr}),
    .vld         (skid_vld_p0),
    .q           (skid_q_p0)
  );

  // Output stage: ID sees a NOP whenever nothing valid is held.
  assign out_valid = main_vld_p0;
  assign out_pc    = main_q_p0[PW-1:32];
  assign out_instr = main_vld_p0 ? main_q_p0[31:0] : NOP_INSTR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               bubble_cnt <= '0;
    else if (!main_vld_p0) bubble_cnt <= sat_inc(bubble_cnt);
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios plus random traffic against a 2-deep queue model.
module tb_if_id_skid_reg;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]  in_pc, out_pc;
  logic [31:0]      in_instr, out_instr;
  logic [CNT_W-1:0] bubble_cnt;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt = 0;
  int   delivered = 0;
  bit   accepted = 1'b0;

  if_id_skid_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor/scoreboard: compares DUT against the queue model mid-cycle, then advances the model.
  always @(negedge clk) begin
    int  sz;
    bit  mf, mi;
    if (rst) begin
      exp_q.delete();
      m_cnt    = 0;
      accepted = 1'b0;
    end else begin
      sz = exp_q.size();
      check("in_ready", {63'd0, in_ready}, {63'd0, sz < 2});
      check("out_valid", {63'd0, out_valid}, {63'd0, sz > 0});
      if (sz > 0) begin
        check("out_pc", {32'd0, out_pc}, {32'd0, exp_q[0].pc});
        check("out_instr", {32'd0, out_instr}, {32'd0, exp_q[0].instr});
      end else begin
        check("nop_instr", {32'd0, out_instr}, {32'd0, NOP});
      end
      check("bubble_cnt", {60'd0, bubble_cnt}, 64'(m_cnt));
      if (sz == 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      mf = (sz > 0) && out_ready;
      mi = in_valid && (sz < 2) && !flush;
      if (mf) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (flush)   exp_q.delete();
      else if (mi) exp_q.push_back('{pc: in_pc, instr: in_instr});
      accepted = mi;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [XLEN-1:0] pc, input logic [31:0] ins, input int budget);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    do begin
      step();
      n++;
    end while (!accepted && n < budget);
    check("accept_in_budget", {63'd0, accepted}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    int d0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();

    // Streaming at full rate
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) offer(XLEN'(k * 4), 32'h0050_0093 + 32'(k << 7), 4);

    // Asynchronous reset in the middle of traffic
    in_valid = 1'b1; in_pc = 32'h0000_0020; in_instr = 32'h0010_0113;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_instr", {32'd0, out_instr}, {32'd0, NOP});
    check("rst_bubble", {60'd0, bubble_cnt}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    step();

    // Stall: fill main and skid, hold off the third, then release
    out_ready = 1'b0;
    d0 = delivered;
    offer(32'h10, 32'h00a0_0093, 4);
    offer(32'h14, 32'h00b0_0113, 4);
    in_valid = 1'b1; in_pc = 32'h18; in_instr = 32'h00c0_0193;
    step();
    check("holdoff_0x18_a", {63'd0, accepted}, 64'd0);
    step();
    check("holdoff_0x18_b", {63'd0, accepted}, 64'd0);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    offer(32'h18, 32'h00c0_0193, 5);
    drain(4);
    check("skid_delivered", 64'(delivered - d0), 64'd3);

    // Flush while full with a new instruction offered
    out_ready = 1'b0;
    offer(32'h30, 32'h0120_0093, 4);
    offer(32'h34, 32'h0130_0113, 4);
    in_valid = 1'b1; in_pc = 32'h20; in_instr = 32'h0140_0193;
    flush = 1'b1;
    d0 = delivered;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_out_instr", {32'd0, out_instr}, {32'd0, NOP});
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    drain(4);
    check("flush_nothing_out", 64'(delivered - d0), 64'd0);

    // Flush coinciding with out_fire
    out_ready = 1'b0;
    offer(32'h40, 32'h0150_0093, 4);
    out_ready = 1'b1; flush = 1'b1;
    in_valid = 1'b1; in_pc = 32'h44; in_instr = 32'h0160_0113;
    d0 = delivered;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flushfire_once", 64'(delivered - d0), 64'd1);
    check("flushfire_empty", {63'd0, out_valid}, 64'd0);
    drain(3);
    check("flushfire_no_replay", 64'(delivered - d0), 64'd1);

    // Bubble counter saturation from a fresh reset
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    drain(20);
    check("bubble_saturate", {60'd0, bubble_cnt}, 64'hF);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) begin
        in_valid = 1'b0; flush = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_instr  = $urandom;
      step();
    end
    flush = 1'b0;
    drain(4);
    check("final_empty", {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
